// File: rtl/my_pe_pkg.sv
// Shared constants and FSM state encoding for the streaming fp32 dot-product PE.
package my_pe_pkg;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_REDUCE = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

endpackage

// File: rtl/fp32_fma.sv
// Pipelined fp32 fused multiply-add r = a*b + c with a single round-to-nearest-even.
// Subnormal inputs and results are flushed to signed zero; NaN/Inf follow IEEE rules.
module fp32_fma #(
  parameter int LATENCY = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [31:0] s_axis_b_tdata,
  input  logic        s_axis_c_tvalid,
  input  logic [31:0] s_axis_c_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);
  logic               in_vld_s;
  logic [31:0]        res_s;
  logic [LATENCY-1:0] vld_r;
  logic [31:0]        dat_r [LATENCY];

  assign in_vld_s = s_axis_a_tvalid & s_axis_b_tvalid & s_axis_c_tvalid;

  // Exact product aligned against c in a 74-bit window, sticky folded into the LSB
  always_comb begin
    logic [7:0]         ea, eb, ec;
    logic [47:0]        mul;
    logic [73:0]        vp, vc, vbig, vsml, shf;
    logic [74:0]        sum, norm;
    logic signed [10:0] ep, ecs, emax, er;
    logic [10:0]        d;
    logic               sp, sc, sbig, ssml, rsign, pbig, nan, pinf, cinf, pzero, czero, rnd;
    logic [24:0]        mant;
    logic [22:0]        frac;
    int                 n;
    ea    = s_axis_a_tdata[30:23];
    eb    = s_axis_b_tdata[30:23];
    ec    = s_axis_c_tdata[30:23];
    sp    = s_axis_a_tdata[31] ^ s_axis_b_tdata[31];
    sc    = s_axis_c_tdata[31];
    nan   = (ea == 8'hFF && s_axis_a_tdata[22:0] != 23'd0) || (eb == 8'hFF && s_axis_b_tdata[22:0] != 23'd0) ||
            (ec == 8'hFF && s_axis_c_tdata[22:0] != 23'd0);
    pinf  = (ea == 8'hFF) || (eb == 8'hFF);
    cinf  = (ec == 8'hFF);
    pzero = (ea == 8'h00) || (eb == 8'h00);
    czero = (ec == 8'h00);
    mul   = {24'd0, 1'b1, s_axis_a_tdata[22:0]} * {24'd0, 1'b1, s_axis_b_tdata[22:0]};
    ep    = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
    ecs   = czero ? ep : $signed({3'b000, ec});
    vp    = {mul, 26'd0};
    vc    = czero ? 74'd0 : {1'b0, 1'b1, s_axis_c_tdata[22:0], 49'd0};
    pbig  = (ep >= ecs);
    emax  = pbig ? ep : ecs;
    d     = pbig ? 11'(ep - ecs) : 11'(ecs - ep);
    vbig  = pbig ? vp : vc;
    vsml  = pbig ? vc : vp;
    sbig  = pbig ? sp : sc;
    ssml  = pbig ? sc : sp;
    if (d >= 11'd74) begin
      shf = {73'd0, |vsml};
    end else begin
      shf = (vsml >> d) | {73'd0, |(vsml & ~({74{1'b1}} << d))};
    end
    if (sbig == ssml) begin
      sum = {1'b0, vbig} + {1'b0, shf};
      rsign = sbig;
    end else if (vbig >= shf) begin
      sum = {1'b0, vbig - shf};
      rsign = sbig;
    end else begin
      sum = {1'b0, shf - vbig};
      rsign = ssml;
    end
    n = 0;
    for (int i = 0; i < 75; i++) begin
      n = sum[i] ? i : n;
    end
    norm = sum << (74 - n);
    rnd  = norm[50] & ((|norm[49:0]) | norm[51]);
    mant = {1'b0, norm[74:51]} + {24'd0, rnd};
    er   = emax + $signed(11'(n)) - 11'sd72 + (mant[24] ? 11'sd1 : 11'sd0);
    frac = mant[24] ? 23'd0 : mant[22:0];
    if (nan || (pinf && pzero) || (pinf && cinf && (sp != sc))) begin
      res_s = 32'h7FC0_0000;
    end else if (pinf) begin
      res_s = {sp, 8'hFF, 23'd0};
    end else if (cinf) begin
      res_s = s_axis_c_tdata;
    end else if (pzero) begin
      res_s = czero ? {sp & sc, 31'd0} : s_axis_c_tdata;
    end else if (sum == 75'd0) begin
      res_s = 32'd0;
    end else if (er >= 11'sd255) begin
      res_s = {rsign, 8'hFF, 23'd0};
    end else if (er <= 11'sd0) begin
      res_s = {rsign, 31'd0};
    end else begin
      res_s = {rsign, er[7:0], frac};
    end
  end

  // Result/valid delay line
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_r <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) dat_r[i] <= 32'd0;
    end else begin
      vld_r[0] <= in_vld_s;
      dat_r[0] <= res_s;
      for (int i = 1; i < LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign m_axis_result_tvalid = vld_r[LATENCY-1];
  assign m_axis_result_tdata  = dat_r[LATENCY-1];

endmodule

// File: rtl/my_pe_acc.sv
// Streaming fp32 dot-product PE: L round-robin partial sums hide the FMA latency,
// then the partials are folded into one result once the vector's last pair is in.
module my_pe_acc
  import my_pe_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FMA_LATENCY = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_a,
  input  logic [DATA_WIDTH-1:0] s_b,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);
  localparam int L  = FMA_LATENCY;
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam int KW = $clog2(L + 1);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("my_pe_acc: DATA_WIDTH must be 32");
  end
  if (FMA_LATENCY < 1) begin : g_bad_latency
    $error("my_pe_acc: FMA_LATENCY must be at least 1");
  end

  logic [1:0]    state_r;
  logic [31:0]   partial_r [L];
  logic [L-1:0]  busy_r;
  logic [PW-1:0] ptr_r;
  logic [PW:0]   tag_r [L];   // {accumulate, slot}; accumulate=0 marks a reduction step
  logic [31:0]   sum_r;
  logic [KW-1:0] k_r;
  logic          wait_r;

  logic          res_vld_s, wb_acc_s, red_done_s, wb_ptr_s, acc_s, red_issue_s, issue_s, drain_done_s;
  logic [PW-1:0] wb_slot_s;
  logic [L-1:0]  wb_mask_s;
  logic [31:0]   res_s, fa_s, fb_s, fc_s, part0_s;

  assign wb_acc_s     = res_vld_s & tag_r[L-1][PW];
  assign red_done_s   = res_vld_s & ~tag_r[L-1][PW];
  assign wb_slot_s    = tag_r[L-1][PW-1:0];
  assign wb_ptr_s     = wb_acc_s & (wb_slot_s == ptr_r);
  assign s_ready      = aresetn & (state_r == ST_ACCUM) & (~busy_r[ptr_r] | wb_ptr_s);
  assign acc_s        = s_valid & s_ready;
  assign red_issue_s  = (state_r == ST_REDUCE) & ~wait_r;
  assign issue_s      = acc_s | red_issue_s;
  assign part0_s      = (wb_acc_s && (wb_slot_s == PW'(0))) ? res_s : partial_r[0];
  assign drain_done_s = ((busy_r & ~wb_mask_s) == {L{1'b0}});
  assign m_valid      = (state_r == ST_OUT);
  assign m_data       = m_valid ? sum_r : FP32_ZERO;

  // Writeback slot decode and FMA operand select (stream pair vs. reduction step)
  always_comb begin
    wb_mask_s = {L{1'b0}};
    if (wb_acc_s) begin
      wb_mask_s[wb_slot_s] = 1'b1;
    end else begin
      wb_mask_s = {L{1'b0}};
    end
    if (state_r == ST_REDUCE) begin
      fa_s = partial_r[k_r[PW-1:0]];
      fb_s = FP32_ONE;
      fc_s = sum_r;
    end else begin
      fa_s = s_a;
      fb_s = s_b;
      fc_s = wb_ptr_s ? res_s : partial_r[ptr_r];
    end
  end

  fp32_fma #(.LATENCY(L)) u_fma (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tvalid      (issue_s),
    .s_axis_a_tdata       (fa_s),
    .s_axis_b_tvalid      (issue_s),
    .s_axis_b_tdata       (fb_s),
    .s_axis_c_tvalid      (issue_s),
    .s_axis_c_tdata       (fc_s),
    .m_axis_result_tvalid (res_vld_s),
    .m_axis_result_tdata  (res_s)
  );

  // FSM, tag pipe, partial-sum writeback and reduction accumulator
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_ACCUM;
      busy_r  <= {L{1'b0}};
      ptr_r   <= {PW{1'b0}};
      sum_r   <= FP32_ZERO;
      k_r     <= {KW{1'b0}};
      wait_r  <= 1'b0;
      for (int i = 0; i < L; i++) begin
        partial_r[i] <= FP32_ZERO;
        tag_r[i]     <= {(PW + 1){1'b0}};
      end
    end else begin
      tag_r[0] <= {acc_s, ptr_r};
      for (int i = 1; i < L; i++) tag_r[i] <= tag_r[i-1];
      for (int i = 0; i < L; i++) begin
        if (wb_mask_s[i]) begin
          partial_r[i] <= res_s;
          busy_r[i]    <= 1'b0;
        end
      end
      case (state_r)
        ST_ACCUM: begin
          // a same-cycle writeback to ptr is overridden by the new issue below
          if (acc_s) begin
            busy_r[ptr_r] <= 1'b1;
            ptr_r         <= (ptr_r == PW'(L - 1)) ? {PW{1'b0}} : ptr_r + PW'(1);
            if (s_last) state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done_s) begin
            sum_r   <= part0_s;
            k_r     <= KW'(1);
            wait_r  <= 1'b0;
            state_r <= (L == 1) ? ST_OUT : ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          if (red_issue_s) wait_r <= 1'b1;
          if (red_done_s) begin
            sum_r  <= res_s;
            wait_r <= 1'b0;
            k_r    <= k_r + KW'(1);
            if (k_r == KW'(L - 1)) state_r <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            for (int i = 0; i < L; i++) partial_r[i] <= FP32_ZERO;
            ptr_r   <= {PW{1'b0}};
            state_r <= ST_ACCUM;
          end
        end
        default: state_r <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_my_pe_acc.sv
// Bench for my_pe_acc at L=4 and L=1: directed and random integer-valued vectors
// checked against an exact sum-of-products model (integer sums stay exact in fp32).
`timescale 1ns/1ps
module tb_my_pe_acc;
  logic             aclk = 1'b0;
  logic             aresetn;
  logic [1:0]       s_valid, s_ready, s_last, m_valid, m_ready;
  logic [1:0][31:0] s_a, s_b, m_data;
  int               vectors = 0;
  int               miscompares = 0;
  int               cyc = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  my_pe_acc #(.DATA_WIDTH(32), .FMA_LATENCY(4)) u_dut4 (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_a(s_a[0]), .s_b(s_b[0]), .s_last(s_last[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_data(m_data[0])
  );

  my_pe_acc #(.DATA_WIDTH(32), .FMA_LATENCY(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_a(s_a[1]), .s_b(s_b[1]), .s_last(s_last[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_data(m_data[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // integer -> fp32 via the simulator's double encoding (exact for |v| < 2^24)
  function automatic logic [31:0] i2f(input int v);
    real         r;
    logic [63:0] d;
    r = v;
    d = $realtobits(r);
    if (v == 0) return 32'h0000_0000;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  task automatic push(input int u, input int a, input int b, input logic last,
                      output int t_acc, output int stalls);
    s_valid[u] = 1'b1;
    s_a[u]     = i2f(a);
    s_b[u]     = i2f(b);
    s_last[u]  = last;
    stalls     = 0;
    t_acc      = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (s_ready[u]) begin
        t_acc = cyc;
        break;
      end
      stalls++;
    end
    if (t_acc < 0) check("push_timeout", {31'd0, s_ready[u]}, 32'd1);
    @(posedge aclk);
    #1;
  endtask

  task automatic get_result(input int u, input string tag, input logic [31:0] exp,
                            input int t0, input int lat, input int hold);
    int t_v;
    t_v = -1;
    m_ready[u] = (hold == 0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge aclk);
      if (m_valid[u]) begin
        t_v = cyc;
        break;
      end
    end
    if (t_v < 0) begin
      check({tag, "_timeout"}, {31'd0, m_valid[u]}, 32'd1);
      m_ready[u] = 1'b1;
      return;
    end
    check({tag, "_latency"}, t_v - t0, lat);
    check({tag, "_data"}, m_data[u], exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check({tag, "_hold_valid"}, {31'd0, m_valid[u]}, 32'd1);
      check({tag, "_hold_data"}, m_data[u], exp);
    end
    m_ready[u] = 1'b1;
    @(negedge aclk);
    check({tag, "_after_valid"}, {31'd0, m_valid[u]}, 32'd0);
    check({tag, "_after_data"}, m_data[u], 32'd0);
  endtask

  task automatic run_vec(input int u, input string tag, input int av[$], input int bv[$], input int hold);
    int t0, st, tot, acc;
    tot = 0;
    acc = 0;
    t0  = 0;
    @(posedge aclk);
    #1;
    foreach (av[i]) begin
      push(u, av[i], bv[i], (i == av.size() - 1), t0, st);
      tot += st;
      acc += av[i] * bv[i];
    end
    s_valid[u] = 1'b0;
    s_last[u]  = 1'b0;
    check({tag, "_stalls"}, tot, 32'd0);
    @(negedge aclk);
    check({tag, "_ready_low"}, {31'd0, s_ready[u]}, 32'd0);
    get_result(u, tag, i2f(acc), t0, (u == 0) ? 20 : 2, hold);
  endtask

  initial begin
    int av[$], bv[$];
    int t0, st, len;
    aresetn = 1'b0;
    s_valid = 2'b00;
    s_last  = 2'b00;
    s_a     = '0;
    s_b     = '0;
    m_ready = 2'b11;
    #1;
    check("reset_s_ready", {30'd0, s_ready}, 32'd0);
    check("reset_m_valid", {30'd0, m_valid}, 32'd0);
    check("reset_m_data4", m_data[0], 32'd0);
    #22 aresetn = 1'b1;
    @(negedge aclk);
    check("first_ready", {30'd0, s_ready}, 32'd3);

    run_vec(0, "dot3", '{1, 2, 3}, '{4, 5, 6}, 0);
    run_vec(0, "single", '{2}, '{3}, 0);
    run_vec(0, "ten_ones", '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1}, '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1}, 0);
    run_vec(0, "hold", '{3, -2}, '{5, 4}, 7);
    run_vec(0, "after_clear", '{1}, '{1}, 0);

    for (int v = 0; v < 6; v++) begin
      av.delete();
      bv.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        av.push_back(int'($urandom_range(0, 32)) - 16);
        bv.push_back(int'($urandom_range(0, 32)) - 16);
      end
      run_vec(0, "rand4", av, bv, $urandom_range(0, 3));
    end

    // reset with products still inside the FMA pipeline
    @(posedge aclk);
    #1;
    push(0, 7, 9, 1'b0, t0, st);
    push(0, 5, 3, 1'b0, t0, st);
    push(0, 6, 6, 1'b0, t0, st);
    s_valid[0] = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    check("midreset_s_ready", {31'd0, s_ready[0]}, 32'd0);
    check("midreset_m_valid", {31'd0, m_valid[0]}, 32'd0);
    check("midreset_m_data", m_data[0], 32'd0);
    @(posedge aclk);
    #2 aresetn = 1'b1;
    @(negedge aclk);
    check("post_reset_ready", {31'd0, s_ready[0]}, 32'd1);
    run_vec(0, "post_reset", '{2}, '{2}, 0);

    run_vec(1, "l1_dot", '{1, 2}, '{1, 1}, 0);
    for (int v = 0; v < 4; v++) begin
      av.delete();
      bv.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        av.push_back(int'($urandom_range(0, 32)) - 16);
        bv.push_back(int'($urandom_range(0, 32)) - 16);
      end
      run_vec(1, "rand1", av, bv, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

endmodule
